line_packer: RTL and testbench



---
 rtl/dc_pkg.sv | 19 +
 rtl/line_buf.sv | 36 +++
 rtl/line_packer.sv | 143 ++++++++++++++
 tb/tb_line_packer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_pkg.sv
// Shared constants, FSM state type and lane-width helper for the line packer.
package dc_pkg;

  localparam int LINE_LEN = 720;

  // Bit positions inside the MODE field.
  localparam int MODE_W3  = 1;
  localparam int MODE_REV = 0;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic logic [1:0] bytes_per_beat(input logic [1:0] mode);
    return mode[MODE_W3] ? 2'd3 : 2'd2;
  endfunction

endpackage

// File: rtl/line_buf.sv
// Line storage: three byte-lane writes at consecutive addresses, one registered read.
module line_buf #(
  parameter int DEPTH = 720,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    wr_en,
  input  logic [AW-1:0] wr_base,
  input  logic [7:0]    wr_a,
  input  logic [7:0]    wr_b,
  input  logic [7:0]    wr_c,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam logic [AW-1:0] OFS1 = AW'(1);
  localparam logic [AW-1:0] OFS2 = AW'(2);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en[0]) mem[wr_base]        <= wr_a;
    if (wr_en[1]) mem[wr_base + OFS1] <= wr_b;
    if (wr_en[2]) mem[wr_base + OFS2] <= wr_c;
  end

  // Read data falls back to zero when no read is requested, so the bus idles at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rd_data <= '0;
    else if (rd_en)  rd_data <= mem[rd_addr];
    else             rd_data <= '0;
  end

endmodule

// File: rtl/line_packer.sv
// Packs 2/3-byte converter beats into a line (forward or reverse), then replays it
// as an addressed byte stream. Handshake: a beat transfers on a rising edge where i_VALID && o_READY.
module line_packer #(
  parameter int LINE_LEN = dc_pkg::LINE_LEN,
  parameter int AW       = 10
) (
  input  logic           CLK_30MHZ,
  input  logic           RSTN,
  input  logic [1:0]     MODE,
  input  logic [7:0]     i_DATA_A,
  input  logic [7:0]     i_DATA_B,
  input  logic [7:0]     i_DATA_C,
  input  logic           i_VALID,
  output logic           o_READY,
  output logic [AW-1:0]  o_ADDR,
  output logic [7:0]     o_DATA,
  output logic           o_LINE_DONE,
  output logic           o_BUSY,
  output dc_pkg::state_t dbg_state
);
  import dc_pkg::*;

  localparam logic [AW-1:0] LEN   = AW'(LINE_LEN);
  localparam logic [AW-1:0] LAST2 = AW'(LINE_LEN / 2 - 1);
  localparam logic [AW-1:0] LAST3 = AW'(LINE_LEN / 3 - 1);
  localparam logic [AW-1:0] ONE   = AW'(1);

  state_t        state, state_d;
  logic [AW-1:0] beat_cnt, beat_cnt_d;
  logic [AW-1:0] drain_cnt, drain_cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          ready_d, busy_d, done_d;
  logic [AW-1:0] addr_d;

  logic [1:0]    mode_eff;
  logic [AW-1:0] g;
  logic [AW-1:0] base;
  logic          accept;
  logic          last_beat;
  logic [2:0]    wr_en;
  logic          rd_en;

  // Beat 0 uses the live MODE; later beats use the copy latched when beat 0 was accepted.
  always_comb begin
    mode_eff  = (beat_cnt == '0) ? MODE : mode_q;
    g         = AW'(bytes_per_beat(mode_eff));
    if (mode_eff[MODE_REV]) base = LEN - g * (beat_cnt + ONE);
    else                    base = g * beat_cnt;
    accept    = (state == FILL) && i_VALID && o_READY;
    last_beat = beat_cnt == (mode_eff[MODE_W3] ? LAST3 : LAST2);
  end

  always_ff @(posedge CLK_30MHZ or negedge RSTN) begin
    if (!RSTN) begin
      state       <= FILL;
      beat_cnt    <= '0;
      drain_cnt   <= '0;
      mode_q      <= '0;
      o_READY     <= 1'b0;
      o_ADDR      <= '0;
      o_LINE_DONE <= 1'b0;
      o_BUSY      <= 1'b0;
    end else begin
      state       <= state_d;
      beat_cnt    <= beat_cnt_d;
      drain_cnt   <= drain_cnt_d;
      mode_q      <= mode_d;
      o_READY     <= ready_d;
      o_ADDR      <= addr_d;
      o_LINE_DONE <= done_d;
      o_BUSY      <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      FILL:    if (accept && last_beat) state_d = DRAIN;
      DRAIN:   if (drain_cnt == LEN)    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    beat_cnt_d  = beat_cnt;
    drain_cnt_d = drain_cnt;
    mode_d      = mode_q;
    ready_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    addr_d      = '0;
    wr_en       = '0;
    rd_en       = 1'b0;
    case (state)
      FILL: begin
        ready_d     = 1'b1;
        drain_cnt_d = '0;
        if (accept) begin
          wr_en = {mode_eff[MODE_W3], 2'b11};
          if (beat_cnt == '0) mode_d = MODE;
          if (last_beat) begin
            ready_d    = 1'b0;
            busy_d     = 1'b1;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt + ONE;
          end
        end
      end
      DRAIN: begin
        // drain_cnt == LEN is the idle cycle after the last byte.
        if (drain_cnt == LEN) begin
          done_d = 1'b1;
        end else begin
          busy_d      = 1'b1;
          rd_en       = 1'b1;
          addr_d      = drain_cnt + ONE;
          drain_cnt_d = drain_cnt + ONE;
        end
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

  line_buf #(
    .DEPTH (LINE_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (CLK_30MHZ),
    .rst_n   (RSTN),
    .wr_en   (wr_en),
    .wr_base (base),
    .wr_a    (i_DATA_A),
    .wr_b    (i_DATA_B),
    .wr_c    (i_DATA_C),
    .rd_en   (rd_en),
    .rd_addr (drain_cnt),
    .rd_data (o_DATA)
  );

endmodule

// File: tb/tb_line_packer.sv
// Directed bench for line_packer: probe-vector table plus multi-cycle corner sequences.
module tb_line_packer;

  localparam int LEN = 720;
  localparam int AW  = 10;
  localparam int P_SEQ = 0;
  localparam int P_INV = 1;

  logic          clk;
  logic          rstn;
  logic [1:0]    mode;
  logic [7:0]    data_a, data_b, data_c;
  logic          valid;
  logic          ready;
  logic [AW-1:0] addr;
  logic [7:0]    data;
  logic          line_done;
  logic          busy;
  dc_pkg::state_t dbg_state;

  line_packer #(.LINE_LEN(LEN), .AW(AW)) dut (
    .CLK_30MHZ   (clk),
    .RSTN        (rstn),
    .MODE        (mode),
    .i_DATA_A    (data_a),
    .i_DATA_B    (data_b),
    .i_DATA_C    (data_c),
    .i_VALID     (valid),
    .o_READY     (ready),
    .o_ADDR      (addr),
    .o_DATA      (data),
    .o_LINE_DONE (line_done),
    .o_BUSY      (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [AW+7:0] exp_q[$];
  logic [7:0]    exp_line[LEN];
  logic [7:0]    cap[LEN];
  int            done_cyc  = 0;
  bit            done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (busy) check("ready_in_drain", {31'd0, ready}, 32'd0);
      if (addr != '0) begin
        if (exp_q.size() == 0) check("extra_addr", {22'd0, addr}, 32'd0);
        else check("drain_byte", {14'd0, addr, data}, {14'd0, exp_q.pop_front()});
        if (int'(addr) <= LEN) cap[int'(addr) - 1] = data;
      end
      if (line_done) begin
        done_cyc  = cyc;
        done_seen = 1'b1;
        check("done_idle_bus", {14'd0, addr, data}, 32'd0);
      end
    end
  end

  // ---------------- model helpers ----------------
  function automatic logic [7:0] lane_val(input int pat, input int g, input int k, input int j);
    if (pat == P_SEQ) return 8'(g * k + j);
    case (j)
      0:       return 8'(k);
      1:       return ~8'(k);
      default: return 8'(k + 128);
    endcase
  endfunction

  function automatic int byte_idx(input logic [1:0] m, input int k, input int j);
    int g;
    g = m[1] ? 3 : 2;
    if (m[0]) return LEN - g * (k + 1) + j;
    return g * k + j;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_line(input logic [1:0] m, input int pat, input int gap_pct,
                            input bit hold, input int sw_at, input logic [1:0] sw_mode,
                            output int e);
    int g, n, k, budget;
    logic rdy;
    g = m[1] ? 3 : 2;
    n = LEN / g;
    k = 0;
    budget = 0;
    e = -1;
    done_seen = 1'b0;
    mode = m;
    while (k < n && budget < 4000) begin
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        valid  = 1'b0;
        data_a = 8'($urandom_range(255, 0));
      end else begin
        valid  = 1'b1;
        data_a = lane_val(pat, g, k, 0);
        data_b = lane_val(pat, g, k, 1);
        data_c = lane_val(pat, g, k, 2);
      end
      rdy = ready;
      @(posedge clk);
      #1;
      budget++;
      if (valid && rdy) begin
        for (int j = 0; j < g; j++) exp_line[byte_idx(m, k, j)] = lane_val(pat, g, k, j);
        if (k == n - 1) begin
          e = cyc;
          check("e_ready_low", {31'd0, ready}, 32'd0);
          check("e_busy_high", {31'd0, busy}, 32'd1);
        end
        k++;
        if (k == sw_at) mode = sw_mode;
      end
    end
    if (k < n) check("fill_timeout", k, n);
    valid = hold;
    if (hold) begin
      data_a = 8'($urandom_range(255, 0));
      data_b = 8'($urandom_range(255, 0));
      data_c = 8'($urandom_range(255, 0));
    end
    for (int i = 0; i < LEN; i++) exp_q.push_back({AW'(i + 1), exp_line[i]});
  endtask

  task automatic wait_drain(input int e);
    int n;
    n = 0;
    while (!done_seen && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!done_seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("done_timing", done_cyc - e, 32'd721);
      @(posedge clk);
      #1;
      check("ready_after_done", {31'd0, ready}, 32'd1);
      check("done_one_cycle", {31'd0, line_done}, 32'd0);
    end
    valid = 1'b0;
    done_seen = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0] m;
    int         pat;
    int         probe;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int e, n;
    vecs[0]  = '{2'b00, P_SEQ, 1,   8'h00};
    vecs[1]  = '{2'b00, P_SEQ, 720, 8'hCF};
    vecs[2]  = '{2'b00, P_SEQ, 257, 8'h00};
    vecs[3]  = '{2'b01, P_INV, 1,   8'h67};
    vecs[4]  = '{2'b01, P_INV, 2,   8'h98};
    vecs[5]  = '{2'b01, P_INV, 719, 8'h00};
    vecs[6]  = '{2'b01, P_INV, 720, 8'hFF};
    vecs[7]  = '{2'b10, P_SEQ, 720, 8'hCF};
    vecs[8]  = '{2'b10, P_SEQ, 3,   8'h02};
    vecs[9]  = '{2'b11, P_SEQ, 1,   8'hCD};
    vecs[10] = '{2'b11, P_INV, 1,   8'hEF};
    vecs[11] = '{2'b11, P_INV, 720, 8'h80};
    vecs[12] = '{2'b10, P_INV, 2,   8'hFF};

    rstn = 1'b0;
    mode = 2'b00;
    valid = 1'b0;
    data_a = '0;
    data_b = '0;
    data_c = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_addr",  {22'd0, addr}, 32'd0);
    check("rst_data",  {24'd0, data}, 32'd0);
    check("rst_done",  {31'd0, line_done}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, {31'd0, dc_pkg::FILL});
    rstn = 1'b1;
    #1;
    check("ready_before_edge", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1;
    check("ready_first_edge", {31'd0, ready}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      drive_line(vecs[i].m, vecs[i].pat, 0, 1'b0, -1, 2'b00, e);
      wait_drain(e);
      check($sformatf("vec%0d_probe", i), {24'd0, cap[vecs[i].probe - 1]}, {24'd0, vecs[i].exp});
    end

    // MODE change mid-line is ignored; the new mode applies to the next line.
    drive_line(2'b10, P_SEQ, 0, 1'b0, 6, 2'b00, e);
    wait_drain(e);
    drive_line(2'b00, P_INV, 0, 1'b0, -1, 2'b00, e);
    wait_drain(e);
    check("mode_next_line", {24'd0, cap[1]}, 32'hFF);

    // Valid gaps during fill, then valid held high through the drain.
    drive_line(2'b11, P_SEQ, 35, 1'b0, -1, 2'b00, e);
    wait_drain(e);
    drive_line(2'b01, P_SEQ, 20, 1'b1, -1, 2'b00, e);
    wait_drain(e);
    drive_line(2'b00, P_SEQ, 0, 1'b0, -1, 2'b00, e);
    wait_drain(e);

    // Reset in the middle of a drain.
    drive_line(2'b10, P_INV, 0, 1'b0, -1, 2'b00, e);
    n = 0;
    while (addr != AW'(300) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_addr300", {22'd0, addr}, 32'd300);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_addr",  {22'd0, addr}, 32'd0);
    check("mid_rst_data",  {24'd0, data}, 32'd0);
    check("mid_rst_done",  {31'd0, line_done}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rel_ready_before_edge", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rel_ready_first_edge", {31'd0, ready}, 32'd1);
    drive_line(2'b00, P_SEQ, 0, 1'b0, -1, 2'b00, e);
    wait_drain(e);
    check("fresh_line_probe", {24'd0, cap[299]}, 32'h2B);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
